// File: rtl/ita_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ita_bus_arbiter
// Purpose  : Two-master, one-target arbiter for the interrupt-agent register
//            bus. Master 0 is the EXU CSR/MMIO port and master 1 is the
//            debug/test requester. The winning command is latched and one
//            target transaction runs at a time. Completion (rdata/ready) is
//            returned only to the granted master. When both masters request
//            together, a round-robin pointer picks the winner, so a waiting
//            master is always served next.
//
// Ports    : clk, rst_n                      clock, async active-low reset
//            m0_valid/wr/rd/addr/wdata       master 0 command
//            m0_rdata/ready                  master 0 completion
//            m1_*                            same as m0_*, for master 1
//            s_valid/wr/rd/addr/wdata        target command
//            s_rdata/ready                   target completion
//            arb_gnt                         one-hot grant {m1,m0}, 00 = idle
//            arb_err                         timeout flag, valid with mX_ready
//
// Options  : ARB_TIMEOUT_EN - when defined, a REQ that sees no s_ready for
//            TMO_CYC cycles completes with rdata=0 and arb_err=1. When it is
//            not defined, REQ waits indefinitely and arb_err is tied 0.
//
// Revision : 1.0 - initial release
// ============================================================================
module ita_bus_arbiter #(
    parameter int XLEN    = 32,
    parameter int AW      = 32,
    parameter int TMO_CYC = 16
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_valid,
    input  logic            m0_wr,
    input  logic            m0_rd,
    input  logic [AW-1:0]   m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    output logic [XLEN-1:0] m0_rdata,
    output logic            m0_ready,

    input  logic            m1_valid,
    input  logic            m1_wr,
    input  logic            m1_rd,
    input  logic [AW-1:0]   m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    output logic [XLEN-1:0] m1_rdata,
    output logic            m1_ready,

    output logic            s_valid,
    output logic            s_wr,
    output logic            s_rd,
    output logic [AW-1:0]   s_addr,
    output logic [XLEN-1:0] s_wdata,
    input  logic [XLEN-1:0] s_rdata,
    input  logic            s_ready,

    output logic [1:0]      arb_gnt,
    output logic            arb_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_rr;          // 1: master 1 wins a tie
    logic [1:0]      r_gnt;

    // The target-side outputs double as the latched command registers.
    // They are loaded only when leaving IDLE, so master input changes
    // during REQ never reach the target.
    logic            r_s_valid;
    logic            r_s_wr;
    logic            r_s_rd;
    logic [AW-1:0]   r_s_addr;
    logic [XLEN-1:0] r_s_wdata;

    logic            r_m0_ready;
    logic            r_m1_ready;
    logic [XLEN-1:0] r_m0_rdata;
    logic [XLEN-1:0] r_m1_rdata;

    logic            w_any;
    logic            w_pick_m1;
    logic            w_cmd_wr;
    logic            w_cmd_rd;
    logic [AW-1:0]   w_cmd_addr;
    logic [XLEN-1:0] w_cmd_wdata;
    logic            w_done;
    logic [XLEN-1:0] w_rsp_rdata;
    logic            w_tmo_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TMO_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // A target answer in the last allowed cycle wins over the timeout.
    assign w_tmo_hit = (r_cnt == c_tmo_last) & ~s_ready;
    assign arb_err   = r_err;
`else
    logic w_unused_tmo;

    assign w_unused_tmo = |TMO_CYC;
    assign w_tmo_hit    = 1'b0;
    assign arb_err      = 1'b0;
`endif

    always_comb begin
        w_any       = m0_valid | m1_valid;
        // A single requester always wins; on a tie the pointer decides.
        w_pick_m1   = (m0_valid & m1_valid) ? r_rr : m1_valid;
        w_cmd_wr    = w_pick_m1 ? m1_wr    : m0_wr;
        w_cmd_rd    = w_pick_m1 ? m1_rd    : m0_rd;
        w_cmd_addr  = w_pick_m1 ? m1_addr  : m0_addr;
        w_cmd_wdata = w_pick_m1 ? m1_wdata : m0_wdata;
        w_done      = s_ready | w_tmo_hit;
        // Writes and timed-out transactions return zero data.
        w_rsp_rdata = (r_s_wr | w_tmo_hit) ? '0 : s_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rr       <= 1'b0;
            r_gnt      <= 2'b00;
            r_s_valid  <= 1'b0;
            r_s_wr     <= 1'b0;
            r_s_rd     <= 1'b0;
            r_s_addr   <= '0;
            r_s_wdata  <= '0;
            r_m0_ready <= 1'b0;
            r_m1_ready <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
            r_cnt      <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_s_valid <= 1'b1;
                        r_s_wr    <= w_cmd_wr;
                        r_s_rd    <= w_cmd_rd & ~w_cmd_wr;
                        r_s_addr  <= w_cmd_addr;
                        r_s_wdata <= w_cmd_wdata;
                        r_gnt     <= w_pick_m1 ? 2'b10 : 2'b01;
`ifdef ARB_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                        r_state   <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (w_done) begin
                        r_s_valid <= 1'b0;
                        r_s_wr    <= 1'b0;
                        r_s_rd    <= 1'b0;
                        r_s_addr  <= '0;
                        r_s_wdata <= '0;
                        if (r_gnt[1]) begin
                            r_m1_ready <= 1'b1;
                            r_m1_rdata <= w_rsp_rdata;
                        end else begin
                            r_m0_ready <= 1'b1;
                            r_m0_rdata <= w_rsp_rdata;
                        end
`ifdef ARB_TIMEOUT_EN
                        r_err     <= w_tmo_hit;
`endif
                        r_state   <= S_RESP;
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end

                S_RESP: begin
                    r_m0_ready <= 1'b0;
                    r_m1_ready <= 1'b0;
                    // Prefer whichever master did not just get served.
                    r_rr       <= ~r_gnt[1];
                    r_gnt      <= 2'b00;
`ifdef ARB_TIMEOUT_EN
                    r_err      <= 1'b0;
`endif
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign s_valid  = r_s_valid;
    assign s_wr     = r_s_wr;
    assign s_rd     = r_s_rd;
    assign s_addr   = r_s_addr;
    assign s_wdata  = r_s_wdata;
    assign m0_ready = r_m0_ready;
    assign m1_ready = r_m1_ready;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;
    assign arb_gnt  = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_ita_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ita_bus_arbiter
// Purpose  : Directed bench for ita_bus_arbiter. Expected grants, target
//            commands and master responses are queued as each test is
//            issued; a target model and a monitor pop and compare them.
//            Build with ARB_TIMEOUT_EN to include the timeout cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ita_bus_arbiter;

    localparam int TMO_CYC = 16;

    logic        clk;
    logic        rst_n;
    logic        m0_valid, m0_wr, m0_rd;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m0_ready;
    logic        m1_valid, m1_wr, m1_rd;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        m1_ready;
    logic        s_valid, s_wr, s_rd;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_ready;
    logic [1:0]  arb_gnt;
    logic        arb_err;

    ita_bus_arbiter #(.XLEN(32), .AW(32), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_valid(m1_valid), .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .s_valid(s_valid), .s_wr(s_wr), .s_rd(s_rd), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready),
        .arb_gnt(arb_gnt), .arb_err(arb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        bit          noresp;
        bit          tmo;
    } tcmd_t;

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    tcmd_t      tq[$];
    resp_t      rq[$];
    logic [1:0] gq[$];

    int n_vec = 0;
    int n_err = 0;
    bit tgt_busy = 1'b0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic void flag(input string nm, input string what);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s", nm, what);
    endfunction

    function automatic void push_t(input logic wr, input logic rd, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata,
                                   input int dly, input bit noresp, input bit tmo);
        tcmd_t t;
        t.wr = wr; t.rd = rd; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        t.dly = dly; t.noresp = noresp; t.tmo = tmo;
        tq.push_back(t);
    endfunction

    function automatic void push_r(input int m, input logic [31:0] rdata, input logic err);
        resp_t r;
        r.m = m; r.rdata = rdata; r.err = err;
        rq.push_back(r);
    endfunction

    // Target model: checks the issued command, then answers after t.dly
    // extra REQ cycles (t.dly = 0 answers in the first REQ cycle).
    initial begin
        tcmd_t t;
        int    n;
        s_ready = 1'b0;
        s_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && s_valid) begin
                if (tq.size() == 0) begin
                    flag("tgt_unexpected", "s_valid=1 with no command expected");
                    n = 0;
                    while (s_valid && n < 100) begin @(negedge clk); n++; end
                end else begin
                    t = tq.pop_front();
                    tgt_busy = 1'b1;
                    if (t.noresp) begin
                        n = 1;
                        while (s_valid && n < 100) begin
                            @(negedge clk);
                            if (s_valid) n++;
                        end
                        if (t.tmo) begin
                            check("tmo_req_cycles", 32'(n), 32'(TMO_CYC));
                            @(negedge clk);
                            s_ready = 1'b1;
                            s_rdata = t.rdata;
                            @(negedge clk);
                            s_ready = 1'b0;
                            s_rdata = '0;
                        end
                    end else begin
                        repeat (t.dly) @(negedge clk);
                        check("s_valid_held", 32'(s_valid), 32'd1);
                        check("s_wr",    32'(s_wr), 32'(t.wr));
                        check("s_rd",    32'(s_rd), 32'(t.rd));
                        check("s_addr",  s_addr,  t.addr);
                        check("s_wdata", s_wdata, t.wdata);
                        s_ready = 1'b1;
                        s_rdata = t.rdata;
                        @(negedge clk);
                        s_ready = 1'b0;
                        s_rdata = '0;
                    end
                    tgt_busy = 1'b0;
                end
            end
        end
    end

    // Monitor: checks each new grant and every ready pulse against the queues.
    initial begin
        logic [1:0] prev_gnt;
        resp_t      r;
        prev_gnt = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_gnt = 2'b00;
            end else begin
                if (arb_gnt != 2'b00 && prev_gnt == 2'b00) begin
                    if (gq.size() == 0)
                        flag("grant_unexpected", $sformatf("got arb_gnt=%b, want none", arb_gnt));
                    else
                        check("arb_gnt", 32'(arb_gnt), 32'(gq.pop_front()));
                end
                prev_gnt = arb_gnt;
                if (m0_ready || m1_ready) begin
                    if (rq.size() == 0) begin
                        flag("ready_unexpected",
                             $sformatf("got m0_ready=%b m1_ready=%b, want none", m0_ready, m1_ready));
                    end else begin
                        r = rq.pop_front();
                        check("ready_sel", 32'({m1_ready, m0_ready}), (r.m == 0) ? 32'd1 : 32'd2);
                        check("rdata", (r.m == 0) ? m0_rdata : m1_rdata, r.rdata);
                        check("arb_err", 32'(arb_err), 32'(r.err));
                    end
                end
            end
        end
    end

    // Master driver. Call right after a negedge; lat counts cycles from the
    // cycle valid is raised (cycle 0) to the cycle ready is seen.
    task automatic do_req(input int m, input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat);
        logic rdy;
        if (m == 0) begin
            m0_wr = wr; m0_rd = rd; m0_addr = addr; m0_wdata = wdata; m0_valid = 1'b1;
        end else begin
            m1_wr = wr; m1_rd = rd; m1_addr = addr; m1_wdata = wdata; m1_valid = 1'b1;
        end
        lat = 0;
        rdy = 1'b0;
        while (!rdy && lat < 200) begin
            @(negedge clk);
            lat++;
            rdy = (m == 0) ? m0_ready : m1_ready;
        end
        if (!rdy) flag("ready_timeout", $sformatf("master %0d got no ready in 200 cycles", m));
        if (m == 0) m0_valid = 1'b0;
        else        m1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rq.size() != 0 || tq.size() != 0 || gq.size() != 0 || tgt_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            flag("drain_timeout", "expected traffic never completed");
            rq.delete(); tq.delete(); gq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, lat1, n;
        rst_n = 1'b0;
        m0_valid = 1'b0; m0_wr = 1'b0; m0_rd = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_valid = 1'b0; m1_wr = 1'b0; m1_rd = 1'b0; m1_addr = '0; m1_wdata = '0;

        // Reset state
        @(negedge clk);
        check("rst_s_valid",  32'(s_valid), 32'd0);
        check("rst_s_cmd",    32'({s_wr, s_rd}), 32'd0);
        check("rst_s_addr",   s_addr, 32'd0);
        check("rst_s_wdata",  s_wdata, 32'd0);
        check("rst_ready",    32'({m1_ready, m0_ready}), 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check("rst_m1_rdata", m1_rdata, 32'd0);
        check("rst_gnt_err",  32'({arb_gnt, arb_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // m0 read, target answers in 2nd REQ cycle
        gq.push_back(2'b01);
        push_t(1'b0, 1'b1, 32'h0200_BFF8, 32'h0, 32'h1234_5678, 1, 1'b0, 1'b0);
        push_r(0, 32'h1234_5678, 1'b0);
        do_req(0, 1'b0, 1'b1, 32'h0200_BFF8, 32'h0, lat1);
        check("m0_read_latency", 32'(lat1), 32'd3);
        wait_idle();

        // Simultaneous requests after reset: m0 first, then m1
        pulse_reset();
        gq.push_back(2'b01); gq.push_back(2'b10);
        push_t(1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'hAAAA_0001, 0, 1'b0, 1'b0);
        push_t(1'b0, 1'b1, 32'h0000_0020, 32'h0, 32'hBBBB_0002, 2, 1'b0, 1'b0);
        push_r(0, 32'hAAAA_0001, 1'b0);
        push_r(1, 32'hBBBB_0002, 1'b0);
        fork
            begin int l0; do_req(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, l0); end
            begin int l1; do_req(1, 1'b0, 1'b1, 32'h0000_0020, 32'h0, l1); end
        join
        wait_idle();

        // Back-to-back m0 against a pending m1: grants 01,10,01
        gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b01);
        push_t(1'b0, 1'b1, 32'h0000_0100, 32'h0, 32'h0000_0A0A, 0, 1'b0, 1'b0);
        push_t(1'b0, 1'b1, 32'h0000_0200, 32'h0, 32'h0000_0B0B, 1, 1'b0, 1'b0);
        push_t(1'b0, 1'b1, 32'h0000_0104, 32'h0, 32'h0000_0C0C, 0, 1'b0, 1'b0);
        push_r(0, 32'h0000_0A0A, 1'b0);
        push_r(1, 32'h0000_0B0B, 1'b0);
        push_r(0, 32'h0000_0C0C, 1'b0);
        fork
            begin int l2; do_req(1, 1'b0, 1'b1, 32'h0000_0200, 32'h0, l2); end
            begin
                int l3;
                do_req(0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, l3);
                do_req(0, 1'b0, 1'b1, 32'h0000_0104, 32'h0, l3);
            end
        join
        wait_idle();

        // m1 write; master scrambles its command during REQ
        gq.push_back(2'b10);
        push_t(1'b1, 1'b0, 32'h0200_4000, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 3, 1'b0, 1'b0);
        push_r(1, 32'h0000_0000, 1'b0);
        fork
            begin int l4; do_req(1, 1'b1, 1'b0, 32'h0200_4000, 32'hA5A5_A5A5, l4); end
            begin
                int k = 0;
                @(negedge clk);
                while (!s_valid && k < 20) begin @(negedge clk); k++; end
                m1_addr = 32'hFFFF_0000; m1_wdata = 32'h0BAD_0BAD; m1_wr = 1'b0; m1_rd = 1'b1;
            end
        join
        wait_idle();

        // Both wr and rd set: write wins, read data is zero
        gq.push_back(2'b01);
        push_t(1'b1, 1'b0, 32'h0000_0030, 32'h1122_3344, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
        push_r(0, 32'h0000_0000, 1'b0);
        do_req(0, 1'b1, 1'b1, 32'h0000_0030, 32'h1122_3344, lat);
        wait_idle();

        // Reset asserted while in REQ
        gq.push_back(2'b01);
        push_t(1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'h0, 0, 1'b1, 1'b0);
        m0_wr = 1'b0; m0_rd = 1'b1; m0_addr = 32'h0000_0040; m0_valid = 1'b1;
        n = 0;
        while (!s_valid && n < 20) begin @(negedge clk); n++; end
        check("rst_test_in_req", 32'(s_valid), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_s_valid", 32'(s_valid), 32'd0);
        check("rst_req_gnt",     32'(arb_gnt), 32'd0);
        check("rst_req_ready",   32'({m1_ready, m0_ready}), 32'd0);
        m0_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_idle();
        gq.push_back(2'b01); gq.push_back(2'b10);
        push_t(1'b0, 1'b1, 32'h0000_0050, 32'h0, 32'h5050_5050, 0, 1'b0, 1'b0);
        push_t(1'b0, 1'b1, 32'h0000_0060, 32'h0, 32'h6060_6060, 0, 1'b0, 1'b0);
        push_r(0, 32'h5050_5050, 1'b0);
        push_r(1, 32'h6060_6060, 1'b0);
        fork
            begin int l5; do_req(0, 1'b0, 1'b1, 32'h0000_0050, 32'h0, l5); end
            begin int l6; do_req(1, 1'b0, 1'b1, 32'h0000_0060, 32'h0, l6); end
        join
        wait_idle();

`ifdef ARB_TIMEOUT_EN
        // Target never answers: timeout completion, late s_ready ignored
        gq.push_back(2'b01);
        push_t(1'b0, 1'b1, 32'h0000_0070, 32'h0, 32'h9999_9999, 0, 1'b1, 1'b1);
        push_r(0, 32'h0000_0000, 1'b1);
        do_req(0, 1'b0, 1'b1, 32'h0000_0070, 32'h0, lat);
        check("tmo_latency", 32'(lat), 32'(TMO_CYC + 1));
        wait_idle();

        // Answer in the last allowed REQ cycle is a normal completion
        gq.push_back(2'b01);
        push_t(1'b0, 1'b1, 32'h0000_0074, 32'h0, 32'h5A5A_5A5A, TMO_CYC - 1, 1'b0, 1'b0);
        push_r(0, 32'h5A5A_5A5A, 1'b0);
        do_req(0, 1'b0, 1'b1, 32'h0000_0074, 32'h0, lat);
        wait_idle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
